// File: rtl/regwb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regwb_arbiter_pkg
// Shared types for the register-file write path. The register file, the
// mult/div unit and the write-back arbiter all use these definitions.
//   word_t       : 32-bit register data word
//   creg_addr_t  : 5-bit architectural register address
//   wb_req_t     : one register write request {wa, wd}
// -----------------------------------------------------------------------------
package regwb_arbiter_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  creg_addr_t;

   typedef struct packed {
      creg_addr_t wa;
      word_t      wd;
   } wb_req_t;

   localparam int NUM_REGS = 32;

endpackage

// File: rtl/regwb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regwb_arbiter_if
// Bundle of every non-clock/reset signal of the write-back arbiter.
//   Port A  : a_we, a_wa, a_wd          (pipeline write-back, no backpressure)
//   Port B  : b_valid, b_ready, b_wa, b_wd (long-latency results)
//   Issue   : issue_valid, issue_wa     (marks a register as pending)
//   RF write: write_enable, wa3, wd3    (registered write port)
//   Decode  : ra1/ra2, rf_rd1/rf_rd2 in; rd1/rd2, busy1/busy2 out
//
// Port B handshake: a result transfers on a rising clock edge where both
// b_valid and b_ready are high. b_ready depends only on registered state
// and reset, never on b_valid; the producer holds b_wa/b_wd stable while
// b_valid is high and b_ready is low.
//
// slave  : arbiter side
// master : producer/decode side (pipeline, long-latency units, testbench)
// -----------------------------------------------------------------------------
interface regwb_arbiter_if;
   import regwb_arbiter_pkg::*;

   logic       a_we;
   creg_addr_t a_wa;
   word_t      a_wd;

   logic       b_valid;
   logic       b_ready;
   creg_addr_t b_wa;
   word_t      b_wd;

   logic       issue_valid;
   creg_addr_t issue_wa;

   logic       write_enable;
   creg_addr_t wa3;
   word_t      wd3;

   creg_addr_t ra1;
   creg_addr_t ra2;
   word_t      rf_rd1;
   word_t      rf_rd2;
   word_t      rd1;
   word_t      rd2;
   logic       busy1;
   logic       busy2;

   modport slave (
      input  a_we, a_wa, a_wd,
      input  b_valid, b_wa, b_wd,
      output b_ready,
      input  issue_valid, issue_wa,
      output write_enable, wa3, wd3,
      input  ra1, ra2, rf_rd1, rf_rd2,
      output rd1, rd2, busy1, busy2
   );

   modport master (
      output a_we, a_wa, a_wd,
      output b_valid, b_wa, b_wd,
      input  b_ready,
      output issue_valid, issue_wa,
      input  write_enable, wa3, wd3,
      output ra1, ra2, rf_rd1, rf_rd2,
      input  rd1, rd2, busy1, busy2
   );

endinterface

// File: rtl/regwb_arbiter_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO of wb_req_t write requests.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : enqueue request; ignored when full unless popping too
//   pop          : dequeue request; ignored when empty
//   head         : oldest entry (valid when !empty)
//   count        : number of stored entries (0..DEPTH)
//   full, empty  : status flags
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module wb_fifo
   import regwb_arbiter_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  wb_req_t       push_data,
   input  logic          pop,
   output wb_req_t       head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   wb_req_t     mem [DEPTH];
   // One extra pointer bit separates "full" from "empty" once the
   // pointers have wrapped onto the same index.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/regwb_arbiter.sv
// -----------------------------------------------------------------------------
// regwb_arbiter
// Merges the in-order pipeline write-back (port A, never stalled) and the
// long-latency result stream (port B, valid/ready) onto the single register
// file write port, keeps a busy scoreboard of registers with a long-latency
// write outstanding, and forwards the registered write to decode reads.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : regwb_arbiter_if.slave (see interface for signal list)
// Parameter:
//   FIFO_DEPTH : port-B buffer entries, power of two, >= 2
// -----------------------------------------------------------------------------
module regwb_arbiter
   import regwb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   regwb_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wb_req_t            fifo_head;
   wb_req_t            fifo_in;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic               a_ok;

   logic               out_we;
   creg_addr_t         out_wa;
   word_t              out_wd;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   // Writes to r0 from port A are dropped and do not take the slot.
   assign a_ok      = bus.a_we && (bus.a_wa != '0);
   assign fifo_pop  = !a_ok && !fifo_empty;

   // Ready comes from the registered count only, so a pop in the same
   // cycle does not reopen a full FIFO until the next cycle.
   assign bus.b_ready = !reset && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign fifo_push   = bus.b_valid && bus.b_ready && !fifo_full;
   assign fifo_in     = '{wa: bus.b_wa, wd: bus.b_wd};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Output register: A first, then FIFO head, else idle.
   // A popped entry addressed to r0 is consumed with write_enable low;
   // wa3/wd3 keep their previous values whenever nothing is written.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_we <= 1'b0;
         out_wa <= '0;
         out_wd <= '0;
      end else if (a_ok) begin
         out_we <= 1'b1;
         out_wa <= bus.a_wa;
         out_wd <= bus.a_wd;
      end else if (fifo_pop && (fifo_head.wa != '0)) begin
         out_we <= 1'b1;
         out_wa <= fifo_head.wa;
         out_wd <= fifo_head.wd;
      end else begin
         out_we <= 1'b0;
      end
   end

   assign bus.write_enable = out_we;
   assign bus.wa3          = out_wa;
   assign bus.wd3          = out_wd;

   // Scoreboard: clear on pop, set on issue; set is applied last so it
   // wins a same-cycle collision. Bit 0 is forced low.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (bus.issue_valid) set_mask[bus.issue_wa] = 1'b1;
      if (fifo_pop)        clr_mask[fifo_head.wa] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
      end
   end

   assign bus.busy1 = busy_q[bus.ra1];
   assign bus.busy2 = busy_q[bus.ra2];

   // Only the registered write is forwarded; r0 never forwards.
   assign bus.rd1 = ((bus.ra1 != '0) && out_we && (out_wa == bus.ra1))
                    ? out_wd : bus.rf_rd1;
   assign bus.rd2 = ((bus.ra2 != '0) && out_we && (out_wa == bus.ra2))
                    ? out_wd : bus.rf_rd2;

endmodule

// File: tb/tb_regwb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regwb_arbiter
// Self-checking bench for regwb_arbiter: a directed vector table, hand
// sequences for the ordering and reset corners, and randomized traffic,
// all shadowed by a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_regwb_arbiter;
   import regwb_arbiter_pkg::*;

   localparam int DEPTH = 2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   regwb_arbiter_if bus();

   regwb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   // Reference model: the write port, a request queue, a busy array.
   logic        m_we;
   creg_addr_t  m_wa3;
   word_t       m_wd3;
   wb_req_t     m_q[$];
   logic [31:0] m_busy;
   logic        m_acc;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic word_t exp_rd(input creg_addr_t ra, input word_t rf);
      return (ra != 0 && m_we && m_wa3 == ra) ? m_wd3 : rf;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic a_we, input creg_addr_t a_wa, input word_t a_wd,
                        input logic b_v, input creg_addr_t b_wa, input word_t b_wd,
                        input logic iv, input creg_addr_t iwa,
                        input creg_addr_t ra1, input word_t rf1);
      bus.a_we = a_we;  bus.a_wa = a_wa;  bus.a_wd = a_wd;
      bus.b_valid = b_v; bus.b_wa = b_wa; bus.b_wd = b_wd;
      bus.issue_valid = iv; bus.issue_wa = iwa;
      bus.ra1 = ra1; bus.rf_rd1 = rf1;
      bus.ra2 = 5'd0; bus.rf_rd2 = 32'h0;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Called at a negedge: check combinational outputs, advance the model
   // by one clock, then check the registered outputs just after the edge.
   task automatic model_cycle();
      logic        rdy;
      logic [31:0] nb;
      wb_req_t     h;
      rdy = !reset && (m_q.size() < DEPTH);
      chk("b_ready", bus.b_ready, rdy);
      chk("rd1", bus.rd1, exp_rd(bus.ra1, bus.rf_rd1));
      chk("rd2", bus.rd2, exp_rd(bus.ra2, bus.rf_rd2));
      chk("busy1", bus.busy1, m_busy[bus.ra1]);
      chk("busy2", bus.busy2, m_busy[bus.ra2]);
      m_acc = 1'b0;
      if (reset) begin
         m_we = 0; m_wa3 = 0; m_wd3 = 0; m_busy = 0;
         m_q.delete();
      end else begin
         nb = m_busy;
         if (bus.a_we && bus.a_wa != 0) begin
            m_we = 1; m_wa3 = bus.a_wa; m_wd3 = bus.a_wd;
         end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            nb[h.wa] = 1'b0;
            if (h.wa != 0) begin
               m_we = 1; m_wa3 = h.wa; m_wd3 = h.wd;
            end else begin
               m_we = 0;
            end
         end else begin
            m_we = 0;
         end
         if (bus.issue_valid && bus.issue_wa != 0) nb[bus.issue_wa] = 1'b1;
         if (bus.b_valid && rdy) begin
            m_q.push_back('{wa: bus.b_wa, wd: bus.b_wd});
            m_acc = 1'b1;
         end
         m_busy = nb;
      end
      @(posedge clk);
      #1;
      chk("write_enable", bus.write_enable, m_we);
      chk("wa3", bus.wa3, m_wa3);
      chk("wd3", bus.wd3, m_wd3);
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic a_we; creg_addr_t a_wa; word_t a_wd;
      logic b_v;  creg_addr_t b_wa; word_t b_wd;
      logic iv;   creg_addr_t iwa;
      creg_addr_t ra1; word_t rf1;
      logic x_rdy; logic x_busy1; word_t x_rd1;
      logic x_we; creg_addr_t x_wa3; word_t x_wd3;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic a_we, creg_addr_t a_wa, word_t a_wd,
                               logic b_v, creg_addr_t b_wa, word_t b_wd,
                               logic iv, creg_addr_t iwa, creg_addr_t ra1, word_t rf1,
                               logic x_rdy, logic x_busy1, word_t x_rd1,
                               logic x_we, creg_addr_t x_wa3, word_t x_wd3);
      vec_t v;
      v = '{a_we, a_wa, a_wd, b_v, b_wa, b_wd, iv, iwa, ra1, rf1,
            x_rdy, x_busy1, x_rd1, x_we, x_wa3, x_wd3};
      return v;
   endfunction

   initial begin
      int sent;
      int cyc;
      vec_t v;

      idle();
      m_we = 0; m_wa3 = 0; m_wd3 = 0; m_busy = 0;

      // ---- reset held for three edges ----
      for (int i = 0; i < 3; i++) step();
      chk("rst_we", bus.write_enable, 1'b0);
      chk("rst_wd3", bus.wd3, 32'h0);
      reset = 1'b0;

      // A write, forwarding, B path with busy, r0 drops, set-wins, contention.
      //            aWe aWa  aWd          bV bWa bWd          iv iwa ra1 rf1        rdy bsy rd1          we wa3 wd3
      vecs.push_back(mk(1, 5, 32'h1234,      0, 0, 0,           0, 0, 5, 32'h0,    1, 0, 32'h0,      1, 5, 32'h1234));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 5, 32'h0,    1, 0, 32'h1234,   0, 5, 32'h1234));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           1, 7, 7, 32'h55,   1, 0, 32'h55,     0, 5, 32'h1234));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 7, 32'h55,   1, 1, 32'h55,     0, 5, 32'h1234));
      vecs.push_back(mk(0, 0, 0,             1, 7, 32'hABCD,    0, 0, 7, 32'h55,   1, 1, 32'h55,     0, 5, 32'h1234));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 7, 32'h55,   1, 1, 32'h55,     1, 7, 32'hABCD));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 7, 32'h55,   1, 0, 32'hABCD,   0, 7, 32'hABCD));
      vecs.push_back(mk(1, 0, 32'hDEAD,      0, 0, 0,           0, 0, 0, 32'h99,   1, 0, 32'h99,     0, 7, 32'hABCD));
      vecs.push_back(mk(0, 0, 0,             1, 0, 32'hBEEF,    0, 0, 0, 32'h99,   1, 0, 32'h99,     0, 7, 32'hABCD));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 0, 32'h99,   1, 0, 32'h99,     0, 7, 32'hABCD));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           1, 3, 3, 32'h0,    1, 0, 32'h0,      0, 7, 32'hABCD));
      vecs.push_back(mk(0, 0, 0,             1, 3, 32'h33,      0, 0, 3, 32'h0,    1, 1, 32'h0,      0, 7, 32'hABCD));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           1, 3, 3, 32'h0,    1, 1, 32'h0,      1, 3, 32'h33));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 3, 32'h0,    1, 1, 32'h33,     0, 3, 32'h33));
      vecs.push_back(mk(1, 10, 32'hA0,       1, 11, 32'hB0,     0, 0, 0, 32'h0,    1, 0, 32'h0,      1, 10, 32'hA0));
      vecs.push_back(mk(1, 12, 32'hA1,       1, 13, 32'hB1,     0, 0, 0, 32'h0,    1, 0, 32'h0,      1, 12, 32'hA1));
      vecs.push_back(mk(1, 14, 32'hA2,       1, 15, 32'hB2,     0, 0, 0, 32'h0,    0, 0, 32'h0,      1, 14, 32'hA2));
      vecs.push_back(mk(1, 16, 32'hA3,       0, 0, 0,           0, 0, 0, 32'h0,    0, 0, 32'h0,      1, 16, 32'hA3));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 0, 32'h0,    0, 0, 32'h0,      1, 11, 32'hB0));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 0, 32'h0,    1, 0, 32'h0,      1, 13, 32'hB1));
      vecs.push_back(mk(0, 0, 0,             0, 0, 0,           0, 0, 0, 32'h0,    1, 0, 32'h0,      0, 13, 32'hB1));

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v.a_we, v.a_wa, v.a_wd, v.b_v, v.b_wa, v.b_wd, v.iv, v.iwa, v.ra1, v.rf1);
         @(negedge clk);
         chk($sformatf("vec%0d_b_ready", i), bus.b_ready, v.x_rdy);
         chk($sformatf("vec%0d_busy1", i), bus.busy1, v.x_busy1);
         chk($sformatf("vec%0d_rd1", i), bus.rd1, v.x_rd1);
         model_cycle();
         chk($sformatf("vec%0d_we", i), bus.write_enable, v.x_we);
         chk($sformatf("vec%0d_wa3", i), bus.wa3, v.x_wa3);
         chk($sformatf("vec%0d_wd3", i), bus.wd3, v.x_wd3);
      end

      // ---- ten B payloads interleaved with A, across pointer wrap ----
      sent = 0;
      cyc  = 0;
      while ((sent < 10 || exp_q.size() > 0) && cyc < 200) begin
         drive((cyc % 3) != 2, 5'($urandom_range(1, 31)), 32'hA000_0000 | cyc,
               sent < 10, 5'($urandom_range(1, 31)), 32'hB000_0000 | sent,
               0, 0, 5'($urandom_range(0, 31)), $urandom);
         step();
         if (m_acc) begin
            exp_q.push_back(32'hB000_0000 | sent);
            sent++;
         end
         if (bus.write_enable && bus.wd3[31:28] == 4'hB) begin
            if (exp_q.size() == 0) chk("b_extra_write", bus.wd3, 32'h0);
            else chk("b_order", bus.wd3, exp_q.pop_front());
         end
         cyc++;
      end
      chk("b_all_written", 32'(exp_q.size() + (10 - sent)), 32'h0);
      idle();
      for (int i = 0; i < 3; i++) step();

      // ---- reset mid-operation: FIFO full, busy bits set ----
      drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 1, 4, 0, 0); step();
      drive(1, 1, 32'h11, 1, 9, 32'h99, 0, 0, 9, 0); step();
      drive(1, 2, 32'h22, 1, 4, 32'h44, 0, 0, 9, 0); step();
      drive(1, 3, 32'h33, 0, 0, 0, 0, 0, 9, 0); bus.ra2 = 5'd4;
      @(negedge clk);
      chk("pre_rst_full", bus.b_ready, 1'b0);
      chk("pre_rst_busy9", bus.busy1, 1'b1);
      model_cycle();
      reset = 1'b1;
      step();
      bus.ra2 = 5'd4;
      step();
      reset = 1'b0;
      idle();
      bus.ra1 = 5'd9; bus.ra2 = 5'd4;
      @(negedge clk);
      chk("post_rst_b_ready", bus.b_ready, 1'b1);
      chk("post_rst_busy9", bus.busy1, 1'b0);
      chk("post_rst_busy4", bus.busy2, 1'b0);
      chk("post_rst_we", bus.write_enable, 1'b0);
      chk("post_rst_wa3", bus.wa3, 5'd0);
      chk("post_rst_wd3", bus.wd3, 32'h0);
      model_cycle();
      step();
      chk("post_rst_no_write", bus.write_enable, 1'b0);

      // ---- randomized traffic ----
      for (int i = 0; i < 500; i++) begin
         creg_addr_t iwa;
         logic       iv;
         iwa = 5'($urandom_range(0, 31));
         iv  = ($urandom_range(0, 3) == 0) && !m_busy[iwa];
         drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
               iv, iwa,
               $urandom_range(0, 1) ? m_wa3 : 5'($urandom_range(0, 31)), $urandom);
         bus.ra2    = $urandom_range(0, 1) ? m_wa3 : 5'($urandom_range(0, 31));
         bus.rf_rd2 = $urandom;
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
